alu_flags: RTL
==============

ALU_FLAGS -- requirements
Module: alu_flags

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port arg_l, input, 8, left ALU operand, same value presented to the add/sub stage.
REQ-004 SHALL have port arg_r, input, 8, right ALU operand, uninverted.
REQ-005 SHALL have port sub, input, 1, 1 = subtract, 0 = add; same signal that drives the add/sub stage.
REQ-006 SHALL have port load_flags_n, input, 1, active-low, capture computed flags at the next edge.
REQ-007 SHALL have port load_bus_n, input, 1, active-low, capture bus[3:0] into flags at the next edge.
REQ-008 SHALL have port outn, input, 1, active-low, drive flags onto bus.
REQ-009 SHALL have port bus, inout, 8, shared CPU data bus.
REQ-010 SHALL have port flags, output, 4, registered flags {N,V,Z,C} for condition logic.

Function
REQ-011 SHALL compute the 9-bit sum s = arg_l + (arg_r XOR {8{sub}}) + sub; result r = s[7:0].
REQ-012 SHALL compute C = s[8], so for subtract 1 means no borrow.
REQ-013 SHALL compute Z = (r == 0x00) and N = r[7].
REQ-014 SHALL compute V = (arg_l[7] == b7) AND (r[7] != arg_l[7]), where b7 = arg_r[7] XOR sub.
REQ-015 SHALL use bit layout C = bit0, Z = bit1, V = bit2, N = bit3.
REQ-016 With load_flags_n low, SHALL register {N,V,Z,C} at the edge; visible on flags after the edge, one-cycle latency.
REQ-017 With load_bus_n low, SHALL register bus[3:0] at the edge; bus[7:4] is ignored.
REQ-018 SHALL give load_bus_n priority over load_flags_n when both are low.
REQ-019 With both loads high, SHALL hold flags unchanged.
REQ-020 With outn low, SHALL drive bus combinationally as {4'b0000, flags}; with outn high, SHALL drive bus to high-Z.
REQ-021 With outn low and load_bus_n low together, SHALL leave flags unchanged (self-load).
REQ-022 SHALL give flag outputs no combinational path from arg_l, arg_r or sub; only registered state reaches flags and bus.

Reset
REQ-023 On rstn low, SHALL immediately clear flags to 0x0, and shadow to 0x0 when present, regardless of clk.
REQ-024 During reset, SHALL ignore loads; bus obeys outn (0x00 if outn low).
REQ-025 A load pending when reset asserts SHALL be lost; first capture occurs on the first edge with rstn high.

Configuration
REQ-026 Macro ALU_FLAGS_SHADOW_EN defined: SHALL add input swap_n (active-low) and a 4-bit shadow register.
REQ-027 On an edge with swap_n low, SHALL exchange flags and shadow in one cycle.
REQ-028 Priority SHALL be load_bus_n > swap_n > load_flags_n; the losing operations have no effect.
REQ-029 Macro ALU_FLAGS_SHADOW_EN undefined: SHALL have no swap_n port and no shadow register; behaviour is exactly REQ-001..025.

Structure
REQ-030 SHALL take flag bit-index constants (FLAG_C=0, FLAG_Z=1, FLAG_V=2, FLAG_N=3) and flag width 4 from shared package cpu_pkg.
REQ-031 SHALL place flag computation (REQ-011..014) in a combinational sub-module alu_flag_calc.
REQ-032 alu_flags SHALL hold only registers, priority muxing and bus driver.

Verification
REQ-033 add 0x7F+0x01, load_flags_n pulse -> flags = 0xC (N=1,V=1,Z=0,C=0).
REQ-034 sub 0x05-0x05 -> flags = 0x3; sub 0x00-0x01 -> flags = 0x8; sub 0x80-0x01 -> flags = 0x5; add 0xFF+0x01 -> flags = 0x3.
REQ-035 bus = 0xA6, load_bus_n and load_flags_n low together -> flags = 0x6; then outn low -> bus reads 0x06; outn high -> bus high-Z.
REQ-036 flags = 0x9, assert rstn low mid-cycle -> flags = 0x0 before the next edge; load_flags_n held low across release -> first capture at the first edge after release.
REQ-037 (ALU_FLAGS_SHADOW_EN) flags = 0x3, shadow = 0x0, swap_n pulse -> flags = 0x0, shadow = 0x3.
REQ-038 (ALU_FLAGS_SHADOW_EN) swap_n and load_flags_n low together -> swap only.
REQ-039 (ALU_FLAGS_SHADOW_EN) swap_n and load_bus_n low together -> bus load only, shadow unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants for flag layout and flag-register update selection.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int FLAG_W = 4;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  typedef enum logic [1:0] {
    LD_HOLD,
    LD_CALC,
    LD_SWAP,
    LD_BUS
  } ld_sel_e;
  function automatic logic [FLAG_W-1:0] pack_flags(input logic n, input logic v, input logic z,
                                                   input logic c);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction
endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: combinational N/V/Z/C from the add/sub stage operands.
module alu_flag_calc
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] arg_l_i,
  input  logic [DATA_W-1:0] arg_r_i,
  input  logic              sub_i,
  output logic [FLAG_W-1:0] flags_o
);
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   s;
  logic [DATA_W-1:0] r;
  always_comb begin
    b = arg_r_i ^ {DATA_W{sub_i}};
    s = {1'b0, arg_l_i} + {1'b0, b} + {{DATA_W{1'b0}}, sub_i};
    r = s[DATA_W-1:0];
    flags_o = pack_flags(r[DATA_W-1],
                         (arg_l_i[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != arg_l_i[DATA_W-1]),
                         r == '0, s[DATA_W]);
  end
endmodule

// File: rtl/alu_flags.sv
// alu_flags: CPU flag register with ALU capture, bus load and tri-state bus readback.
// Optional shadow flag register with swap_n when ALU_FLAGS_SHADOW_EN is defined.
module alu_flags
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] arg_l,
  input  logic [DATA_W-1:0] arg_r,
  input  logic              sub,
  input  logic              load_flags_n,
  input  logic              load_bus_n,
  input  logic              outn,
`ifdef ALU_FLAGS_SHADOW_EN
  input  logic              swap_n,
`endif
  inout  wire  [DATA_W-1:0] bus,
  output logic [FLAG_W-1:0] flags
);
  logic [FLAG_W-1:0] calc;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              swap_req;
  ld_sel_e           sel;
  logic              unused_bus_hi;
  alu_flag_calc u_calc (
    .arg_l_i(arg_l),
    .arg_r_i(arg_r),
    .sub_i  (sub),
    .flags_o(calc)
  );
`ifdef ALU_FLAGS_SHADOW_EN
  logic [FLAG_W-1:0] shadow_q, shadow_d;
  assign swap_req = !swap_n;
  always_comb shadow_d = (sel == LD_SWAP) ? flags_q : shadow_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) shadow_q <= '0;
    else shadow_q <= shadow_d;
`else
  logic [FLAG_W-1:0] shadow_q;
  assign swap_req = 1'b0;
  assign shadow_q = '0;
`endif
  always_comb begin
    sel = !load_bus_n ? LD_BUS : swap_req ? LD_SWAP : !load_flags_n ? LD_CALC : LD_HOLD;
    flags_d = (sel == LD_BUS)  ? bus[FLAG_W-1:0] :
              (sel == LD_SWAP) ? shadow_q :
              (sel == LD_CALC) ? calc : flags_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) flags_q <= '0;
    else flags_q <= flags_d;
  assign unused_bus_hi = ^bus[DATA_W-1:FLAG_W];
  assign flags = flags_q;
  // With outn low the bus carries flags_q, so a simultaneous bus load rewrites the same value.
  assign bus = outn ? {DATA_W{1'bz}} : {{(DATA_W-FLAG_W){1'b0}}, flags_q};
endmodule
